push_pop_sequencer: RTL
=======================

PUSH_POP_SEQUENCER -- requirements
Module: push_pop_sequencer

Interface
REQ-001 Parameter WIDE, default 32, data/address width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin a multi-register transfer, sampled in IDLE only.
REQ-006 is_pop  in  1  1 = POP (load), 0 = PUSH (store); sampled with start.
REQ-007 reg_list  in  9  bits 0-7 = r0-r7; bit 8 = LR for PUSH, PC for POP; sampled with start.
REQ-008 sp_in  in  WIDE  current SP from the register file, sampled with start.
REQ-009 reg_data_in  in  WIDE  register-file read data for read_sel (combinational).
REQ-010 mem_ready  in  1  current memory access completes this cycle.
REQ-011 mem_rdata  in  WIDE  load data, valid when mem_ready=1.
REQ-012 read_sel  out  5  register-file read select.
REQ-013 write_sel / write_en / write_data  out  5 / 1 / WIDE  register-file write port.
REQ-014 mem_req / mem_we / mem_addr / mem_wdata  out  1 / 1 / WIDE / WIDE  memory request.
REQ-015 sp_out / sp_en  out  WIDE / 1  final SP value and its one-cycle write strobe.
REQ-016 busy / done  out  1 / 1  transfer in progress / one-cycle completion pulse.

Function
REQ-017 States: IDLE, ACCESS, FINISH; busy=1 in ACCESS and FINISH.
REQ-018 IDLE, start=1, reg_list!=0: latch list and is_pop, N=popcount(reg_list) (1..9), base = is_pop ? sp_in : sp_in-4N, final SP = is_pop ? sp_in+4N : sp_in-4N, all mod 2^WIDE; next state ACCESS.
REQ-019 IDLE, start=1, reg_list==0: next state FINISH with sp_en=0 there; no memory access, no register write.
REQ-020 start while busy is ignored; is_pop, reg_list and sp_in are not re-sampled.
REQ-021 ACCESS serves lowest set bit k of the latched list; mem_req=1, mem_addr=current address (base in first ACCESS cycle), mem_we=~is_pop.
REQ-022 Register index: k=0..7 -> 5'b00000..5'b00111; k=8 -> 5'b01110 (LR) on PUSH, 5'b01111 (PC) on POP.
REQ-023 PUSH: read_sel = index of k, mem_wdata = reg_data_in combinationally; write_en=0.
REQ-024 POP: read_sel = 5'b11101; with mem_ready=1, write_en=1, write_sel = index of k, write_data = mem_rdata in the same cycle.
REQ-025 mem_ready=0 in ACCESS: hold mem_addr, mem_we, read_sel and the list unchanged (wait states unlimited).
REQ-026 mem_ready=1 in ACCESS: clear bit k, address += 4; if the list is now empty go to FINISH, else stay in ACCESS.
REQ-027 FINISH (one cycle): done=1, sp_en=1 (0 for empty list), sp_out=final SP; next state IDLE.
REQ-028 Latency with mem_ready tied high: done asserts N+1 cycles after the edge sampling start; one access per cycle, no bubbles.
REQ-029 Outside ACCESS: mem_req=0, mem_we=0, write_en=0; read_sel and write_sel = 5'b11101 (NONE).
REQ-030 sp_out holds its last value while sp_en=0.
REQ-031 mem_ready outside ACCESS is ignored.

Reset
REQ-032 Reset asserted: state IDLE immediately; busy, done, mem_req, mem_we, write_en, sp_en = 0; mem_addr, mem_wdata, write_data, sp_out = 0; read_sel and write_sel = 5'b11101.
REQ-033 Reset mid-transfer aborts: no further memory access, register write or SP update; writes already completed remain.

Verification
REQ-034 PUSH {r0,r2,LR} (reg_list=9'h105), sp_in=0x1FFC, mem_ready=1 -> stores to 0x1FF0/0x1FF4/0x1FF8, read_sel 0,2,14 on consecutive cycles; then sp_en with sp_out=0x1FF0, done 4 cycles after start.
REQ-035 POP {r1,PC} (9'h102), sp_in=0x1FF0, rdata 0x11 then 0x40 -> write r1=0x11, then PC (5'b01111)=0x40; addresses 0x1FF0, 0x1FF4; sp_out=0x1FF8.
REQ-036 PUSH {r3}, mem_ready low 3 cycles -> mem_addr=sp_in-4 and read_sel=3 stable 4 cycles; done exactly once, after the completing cycle.
REQ-037 start with reg_list=0 -> done next cycle, sp_en=0, mem_req never high.
REQ-038 Reset during the 2nd access of a 9-register POP -> outputs at reset values at once; next start runs a full correct transfer.
REQ-039 start pulsed again while busy with different list -> ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/push_pop_sequencer.sv
// Multi-register PUSH/POP sequencer: walks a 9-bit register list lowest bit first,
// issuing one stack memory access per set bit and reporting the final SP.
module push_pop_sequencer #(
    parameter int WIDE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_pop,
    input  logic [8:0]      reg_list,
    input  logic [WIDE-1:0] sp_in,
    input  logic [WIDE-1:0] reg_data_in,
    input  logic            mem_ready,
    input  logic [WIDE-1:0] mem_rdata,
    output logic [4:0]      read_sel,
    output logic [4:0]      write_sel,
    output logic            write_en,
    output logic [WIDE-1:0] write_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WIDE-1:0] mem_addr,
    output logic [WIDE-1:0] mem_wdata,
    output logic [WIDE-1:0] sp_out,
    output logic            sp_en,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] FINISH   = 2'd2;
    localparam logic [4:0] SEL_NONE = 5'b11101;

    logic [1:0]      state;
    logic [8:0]      list_q;
    logic            pop_q;
    logic            nonempty_q;
    logic [WIDE-1:0] addr_q;
    logic [WIDE-1:0] final_sp_q;
    logic [WIDE-1:0] sp_out_q;

    logic [3:0]      start_cnt;
    logic [WIDE-1:0] four_n;
    logic [3:0]      cur_k;
    logic [4:0]      cur_idx;
    logic [8:0]      list_next;
    logic            in_access;

    function automatic logic [3:0] popcount9(input logic [8:0] l);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) c = c + {3'b000, l[i]};
        return c;
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [8:0] l);
        logic [3:0] k;
        k = 4'd8;
        for (int i = 8; i >= 0; i--) if (l[i]) k = 4'(i);
        return k;
    endfunction

    // Bit 8 maps to LR when storing and to PC when loading.
    function automatic logic [4:0] reg_index(input logic [3:0] k, input logic pop);
        if (k == 4'd8) return pop ? 5'b01111 : 5'b01110;
        return {1'b0, k};
    endfunction

    assign start_cnt = popcount9(reg_list);
    assign four_n    = WIDE'(start_cnt) << 2;
    assign cur_k     = lowest_bit(list_q);
    assign cur_idx   = reg_index(cur_k, pop_q);
    assign list_next = list_q & (list_q - 9'd1);
    assign in_access = (state == ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            list_q     <= 9'd0;
            pop_q      <= 1'b0;
            nonempty_q <= 1'b0;
            addr_q     <= '0;
            final_sp_q <= '0;
            sp_out_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pop_q  <= is_pop;
                        list_q <= reg_list;
                        if (reg_list != 9'd0) begin
                            addr_q     <= is_pop ? sp_in : sp_in - four_n;
                            final_sp_q <= is_pop ? sp_in + four_n : sp_in - four_n;
                            nonempty_q <= 1'b1;
                            state      <= ACCESS;
                        end else begin
                            nonempty_q <= 1'b0;
                            state      <= FINISH;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        list_q <= list_next;
                        addr_q <= addr_q + WIDE'(4);
                        if (list_next == 9'd0) begin
                            sp_out_q <= final_sp_q;
                            state    <= FINISH;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Access-side outputs are decoded from state so reset silences them immediately.
    assign mem_req    = in_access;
    assign mem_we     = in_access & ~pop_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = (in_access & ~pop_q) ? reg_data_in : '0;
    assign read_sel   = (in_access & ~pop_q) ? cur_idx : SEL_NONE;
    assign write_en   = in_access & pop_q & mem_ready;
    assign write_sel  = write_en ? cur_idx : SEL_NONE;
    assign write_data = write_en ? mem_rdata : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign sp_en      = done & nonempty_q;
    assign sp_out     = sp_out_q;

endmodule
